// File: rtl/uo_arbiter.sv
// Round-robin arbiter sharing one output port among NREQ requesters.
// Each grant captures the winner's word and holds it on out_data for HOLD cycles.
module uo_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int HOLD = 4,
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic [IW-1:0]     grant_id,
  output logic              busy
);

  typedef enum logic {ST_IDLE, ST_HOLD} state_t;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] last_grant;
  logic [7:0]    hold_cnt;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] scan_idx;
  logic [W-1:0]  req_word [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_word
    assign req_word[g] = req_data[g*W +: W];
  end

  // Scan upward from the requester after the last winner, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = IW'((int'(last_grant) + k) % NREQ);
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          state_next         = ST_HOLD;
        end
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (hold_cnt == 8'd0) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // last_grant resets to the top index so requester 0 has first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      out_data   <= '0;
      grant_id   <= '0;
      last_grant <= IW'(NREQ - 1);
      hold_cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE && win_found) begin
        out_data   <= req_word[win_idx];
        grant_id   <= win_idx;
        last_grant <= win_idx;
        hold_cnt   <= 8'(HOLD - 1);
      end else if (state == ST_HOLD && hold_cnt != 8'd0) begin
        hold_cnt <= hold_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uo_arbiter.sv
// Directed bench for uo_arbiter: a round-robin/hold-window model checked every cycle,
// plus literal expectations for the single-grant, fairness, wrap, stability, reset and HOLD=1 cases.
module tb_uo_arbiter;

  localparam int HOLD_T = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [1:0]  grant_id;
  logic        busy;

  logic [3:0]  v1 = '0;
  logic [31:0] d1 = '0;
  logic [3:0]  r1;
  logic [7:0]  od1;
  logic        ov1;
  logic [1:0]  gid1;
  logic        b1;

  int checks = 0;
  int failures = 0;
  logic check_en = 1'b0;

  uo_arbiter #(.NREQ(4), .W(8), .HOLD(HOLD_T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_data(out_data), .out_valid(out_valid),
    .grant_id(grant_id), .busy(busy)
  );

  uo_arbiter #(.NREQ(4), .W(8), .HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_data(d1),
    .req_ready(r1), .out_data(od1), .out_valid(ov1),
    .grant_id(gid1), .busy(b1)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a grant opens a window of HOLD_T valid cycles; winners picked round-robin.
  int         m_last;
  int         m_left;
  int         m_id;
  logic [7:0] m_data;
  int         m_pick;

  function automatic int rr_pick(input int last, input logic [3:0] v);
    for (int s = 1; s <= 4; s++) begin
      if (v[(last + s) % 4]) return (last + s) % 4;
    end
    return -1;
  endfunction

  always_comb m_pick = rr_pick(m_last, req_valid);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last <= 3;
      m_left <= 0;
      m_id   <= 0;
      m_data <= 8'h00;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (m_pick >= 0) begin
      m_last <= m_pick;
      m_id   <= m_pick;
      m_data <= req_data[m_pick*8 +: 8];
      m_left <= HOLD_T;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check_output("model_req_ready", 32'(req_ready),
                   (m_left == 0 && m_pick >= 0) ? 32'(4'b0001 << m_pick) : 32'd0);
      check_output("model_out_valid", 32'(out_valid), 32'(m_left > 0));
      check_output("model_busy", 32'(busy), 32'(m_left > 0));
      check_output("model_out_data", 32'(out_data), 32'(m_data));
      check_output("model_grant_id", 32'(grant_id), 32'(m_id));
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic apply_stimulus(input logic [3:0] v, input logic [31:0] d);
    req_valid = v;
    req_data  = d;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  logic [3:0]  pat_v [4] = '{4'hF, 4'h5, 4'hA, 4'h3};
  logic [31:0] pat_d [4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDEADBEEF};
  int g_cnt;
  int g_idx [8];
  int g_cyc [8];

  initial begin
    step();
    check_en = 1'b1;
    // Reset state
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_out_valid", 32'(out_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_out_data", 32'(out_data), 32'd0);
    check_output("rst_grant_id", 32'(grant_id), 32'd0);
    step();
    rst = 1'b0;
    #1;

    // Single requester 2
    apply_stimulus(4'b0100, 32'h005A0000);
    check_output("single_ready", 32'(req_ready), 32'h4);
    step();
    apply_stimulus(4'b0000, 32'h0);
    for (int c = 1; c <= HOLD_T; c++) begin
      check_output("single_valid", 32'(out_valid), 32'd1);
      check_output("single_data", 32'(out_data), 32'h5A);
      check_output("single_id", 32'(grant_id), 32'd2);
      check_output("single_ready_hold", 32'(req_ready), 32'd0);
      step();
    end
    check_output("single_valid_after", 32'(out_valid), 32'd0);

    // Fairness with all four valid
    do_reset();
    apply_stimulus(4'b1111, 32'h13121110);
    g_cnt = 0;
    for (int c = 0; c < 23; c++) begin
      if (req_ready != 4'b0000) begin
        if (g_cnt < 8) begin
          g_idx[g_cnt] = $clog2(req_ready);
          g_cyc[g_cnt] = c;
        end
        g_cnt++;
      end
      step();
    end
    check_output("fair_grant_count", 32'(g_cnt), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check_output("fair_order", 32'(g_idx[i]), 32'(i % 4));
      check_output("fair_spacing", 32'(g_cyc[i]), 32'(i * 5));
    end
    apply_stimulus(4'b0000, 32'h0);
    step();
    step();
    step();
    step();

    // Wrap-around then stability during the hold of requester 3
    do_reset();
    apply_stimulus(4'b1001, 32'hD3C2B1A0);
    check_output("wrap_first", 32'(req_ready), 32'h1);
    step();
    check_output("wrap_data0", 32'(out_data), 32'hA0);
    for (int c = 0; c < 4; c++) step();
    check_output("wrap_second", 32'(req_ready), 32'h8);
    step();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(pat_v[i], pat_d[i]);
      check_output("stable_data", 32'(out_data), 32'hD3);
      check_output("stable_id", 32'(grant_id), 32'd3);
      check_output("stable_ready", 32'(req_ready), 32'd0);
      if (i < 3) step();
    end
    apply_stimulus(4'b0000, 32'h0);
    step();
    check_output("stable_end_valid", 32'(out_valid), 32'd0);

    // Reset in the 2nd HOLD cycle
    do_reset();
    apply_stimulus(4'b0010, 32'h00007700);
    step();
    apply_stimulus(4'b0000, 32'h0);
    step();
    check_output("midrst_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check_output("midrst_valid", 32'(out_valid), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_data", 32'(out_data), 32'd0);
    step();
    rst = 1'b0;
    #1;
    apply_stimulus(4'b0011, 32'h00002211);
    check_output("midrst_regrant", 32'(req_ready), 32'h1);
    step();
    apply_stimulus(4'b0000, 32'h0);
    check_output("midrst_regrant_data", 32'(out_data), 32'h11);
    for (int c = 0; c < 5; c++) step();

    // HOLD=1 instance, two requesters continuously valid
    do_reset();
    v1 = 4'b0011;
    d1 = 32'h0000B2A1;
    #1;
    check_output("h1_ready0", 32'(r1), 32'h1);
    check_output("h1_valid0", 32'(ov1), 32'd0);
    step();
    check_output("h1_valid1", 32'(ov1), 32'd1);
    check_output("h1_id1", 32'(gid1), 32'd0);
    check_output("h1_data1", 32'(od1), 32'hA1);
    check_output("h1_busy1", 32'(b1), 32'd1);
    step();
    check_output("h1_valid2", 32'(ov1), 32'd0);
    check_output("h1_ready2", 32'(r1), 32'h2);
    step();
    check_output("h1_valid3", 32'(ov1), 32'd1);
    check_output("h1_id3", 32'(gid1), 32'd1);
    check_output("h1_data3", 32'(od1), 32'hB2);
    step();
    check_output("h1_valid4", 32'(ov1), 32'd0);
    v1 = 4'b0000;
    step();

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uo_arbiter.md
UO_ARBITER -- requirements
Module: uo_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing the output port (2..8).
REQ-002 SHALL have parameter W, default 8, output data width in bits.
REQ-003 SHALL have parameter HOLD, default 4, number of cycles each grant drives the output (1..255).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NREQ bits, per-requester data-valid.
REQ-007 SHALL have port req_data, input, NREQ*W bits, requester i occupies bits [i*W +: W].
REQ-008 SHALL have port req_ready, output, NREQ bits, one-hot accept strobe, at most one bit set.
REQ-009 SHALL have port out_data, output, W bits, data presented to the shared output pins.
REQ-010 SHALL have port out_valid, output, 1 bit, high while out_data carries a granted word.
REQ-011 SHALL have port grant_id, output, clog2(NREQ) bits, index of the requester whose word is on out_data.
REQ-012 SHALL have port busy, output, 1 bit, high in state HOLD.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and HOLD.
REQ-014 In IDLE with any req_valid high, SHALL set req_ready for exactly one winner, combinationally, in the same cycle.
REQ-015 Winner SHALL be chosen round-robin: the first valid index scanning upward from last_grant+1, wrapping NREQ-1 -> 0.
REQ-016 On the edge where req_ready[i] and req_valid[i] are both high, SHALL capture req_data[i] into out_data, load grant_id=i, set last_grant=i, load hold counter with HOLD-1, and enter HOLD.
REQ-017 In IDLE with no req_valid high, SHALL keep req_ready all zero and remain in IDLE.
REQ-018 In HOLD, SHALL drive out_valid=1 and busy=1, keep out_data and grant_id constant, keep req_ready all zero, and decrement the counter each cycle.
REQ-019 In HOLD with counter==0, SHALL return to IDLE on the next edge; out_valid is therefore high for exactly HOLD cycles per grant.
REQ-020 In IDLE, SHALL drive out_valid=0 and busy=0, and hold out_data and grant_id at their last values.
REQ-021 Latency: a grant in cycle N SHALL give out_valid high in cycles N+1..N+HOLD; the next grant occurs no earlier than cycle N+HOLD+1.
REQ-022 With HOLD=1, SHALL spend one cycle in HOLD, then return to IDLE; no zero-length hold.
REQ-023 Requesters changing req_valid or req_data during HOLD SHALL NOT affect out_data or grant_id.
REQ-024 A requester that deasserts req_valid before being granted SHALL simply be skipped; no error state.
REQ-025 Requesters SHALL hold req_valid and req_data stable until req_ready; the block does not buffer unaccepted data.

Reset
REQ-026 While rst is high, SHALL force state=IDLE, out_data=0, out_valid=0, busy=0, grant_id=0, req_ready=0, counter=0, and last_grant=NREQ-1, independent of clk.
REQ-027 Setting last_grant to NREQ-1 SHALL give requester 0 first priority after reset.
REQ-028 Reset asserted mid-HOLD SHALL drop out_valid and busy immediately; the interrupted word is discarded and not re-issued.
REQ-029 After rst deasserts, the first arbitration SHALL occur on the first rising edge of clk.

Verification
REQ-030 Single requester: after reset, req_valid=4'b0100, data2=8'h5A -> req_ready=4'b0100 in the same cycle; out_data=8'h5A, grant_id=2, out_valid=1 for 4 cycles, then out_valid=0 for at least 1 cycle.
REQ-031 Fairness: all four valid continuously, data i = 8'h10+i -> grant order 0,1,2,3,0; each grant is spaced 5 cycles apart.
REQ-032 Wrap-around: with last_grant=3, valid=4'b1001 -> requester 0 wins; the next grant goes to 3.
REQ-033 Stability: change req_data and req_valid every cycle during HOLD -> out_data and grant_id unchanged, and req_ready=0 throughout.
REQ-034 Reset mid-operation: assert rst in the 2nd HOLD cycle -> out_valid=0 and out_data=0 without a clock edge; after release, valid=4'b0011 -> requester 0 is granted.
REQ-035 HOLD=1 build: two requesters continuously valid -> out_valid pattern 1,0,1,0 with grant_id alternating 0,1.
